// File: rtl/in_port_if.sv
// in_port_if: signal bundle between the in_port FIFO and its neighbours.
//   slave  modport: the in_port block itself.
//   master modport: the producer (ext_*) plus the CPU side (ld_inr, clr_err, readback).
// Signals:
//   ext_valid / ext_data / ext_ready : producer push handshake
//   ld_inr                           : CPU pop strobe (IN instruction)
//   in_data / in_empty / in_count    : head word and fill status toward the CPU
//   underrun / clr_err               : sticky empty-pop flag and its clear
interface in_port_if #(
   parameter int unsigned WIDTH  = 16,
   parameter int unsigned ADDR_W = 2
);
   logic              ext_valid;
   logic [WIDTH-1:0]  ext_data;
   logic              ext_ready;
   logic              ld_inr;
   logic [WIDTH-1:0]  in_data;
   logic              in_empty;
   logic [ADDR_W:0]   in_count;
   logic              underrun;
   logic              clr_err;

   modport slave (
      input  ext_valid, ext_data, ld_inr, clr_err,
      output ext_ready, in_data, in_empty, in_count, underrun
   );

   modport master (
      output ext_valid, ext_data, ld_inr, clr_err,
      input  ext_ready, in_data, in_empty, in_count, underrun
   );
endinterface

// File: rtl/in_port.sv
// in_port: input-side peripheral for the SIMPLE CPU. An external producer pushes words
// over a valid/ready handshake into a small circular FIFO; the CPU pops one word per IN
// instruction and reads the head combinationally on in_data in the same cycle.
// Ports:
//   clk : system clock, rising edge
//   rst : synchronous active-high reset (priority over everything)
//   bus : in_port_if.slave (ext_valid/ext_data/ext_ready, ld_inr, in_data, in_empty,
//         in_count, underrun, clr_err)
module in_port #(
   parameter int unsigned WIDTH  = 16,
   parameter int unsigned DEPTH  = 4,
   parameter int unsigned ADDR_W = 2
) (
   input  logic      clk,
   input  logic      rst,
   in_port_if.slave  bus
);

   localparam logic [ADDR_W:0] Full = (ADDR_W+1)'(DEPTH);

   logic [WIDTH-1:0]  mem_q [DEPTH];
   logic [ADDR_W-1:0] wr_ptr_q;
   logic [ADDR_W-1:0] rd_ptr_q;
   logic [ADDR_W:0]   count_q;
   logic              underrun_q;

   logic empty;
   logic ready;
   logic push;
   logic pop;

   // Ready comes from registered count only, so a pop never opens ready in the same cycle.
   assign empty = (count_q == '0);
   assign ready = (count_q != Full);
   assign push  = bus.ext_valid & ready;
   assign pop   = bus.ld_inr & ~empty;

   assign bus.ext_ready = ready;
   assign bus.in_empty  = empty;
   assign bus.in_count  = count_q;
   assign bus.underrun  = underrun_q;
   assign bus.in_data   = empty ? '0 : mem_q[rd_ptr_q];

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         underrun_q <= 1'b0;
      end else begin
         if (push) begin
            mem_q[wr_ptr_q] <= bus.ext_data;
            wr_ptr_q        <= wr_ptr_q + ADDR_W'(1);
         end
         if (pop) begin
            rd_ptr_q <= rd_ptr_q + ADDR_W'(1);
         end
         if (push && !pop) begin
            count_q <= count_q + (ADDR_W+1)'(1);
         end else if (pop && !push) begin
            count_q <= count_q - (ADDR_W+1)'(1);
         end
         // A new empty pop beats a clear in the same cycle.
         if (bus.ld_inr && empty) begin
            underrun_q <= 1'b1;
         end else if (bus.clr_err) begin
            underrun_q <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_in_port.sv
// tb_in_port: directed self-checking bench for in_port. Inputs change 1 ns after the
// rising edge; outputs are checked in the settled part of the cycle before the next edge.
module tb_in_port;

   logic clk;
   logic rst;
   int   checks;
   int   errors;

   in_port_if #(.WIDTH(16), .ADDR_W(2)) bus ();

   in_port #(.WIDTH(16), .DEPTH(4), .ADDR_W(2)) u_dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   initial begin
      checks        = 0;
      errors        = 0;
      rst           = 1'b1;
      bus.ext_valid = 1'b1;
      bus.ext_data  = 16'hDEAD;
      bus.ld_inr    = 1'b0;
      bus.clr_err   = 1'b0;
      #1;

      // T1 reset held 2 cycles with ext_valid high
      tick();
      tick();
      rst           = 1'b0;
      bus.ext_valid = 1'b0;
      #1;
      chk("rst_ready", 32'(bus.ext_ready), 32'd1);
      chk("rst_empty", 32'(bus.in_empty), 32'd1);
      chk("rst_count", 32'(bus.in_count), 32'd0);
      chk("rst_data", 32'(bus.in_data), 32'h0);
      chk("rst_underrun", 32'(bus.underrun), 32'd0);

      // T2 fill to full, then hold a word against a full FIFO
      for (int i = 1; i <= 4; i++) begin
         bus.ext_valid = 1'b1;
         bus.ext_data  = 16'(16'h1111 * i);
         tick();
      end
      chk("fill_count", 32'(bus.in_count), 32'd4);
      chk("fill_ready", 32'(bus.ext_ready), 32'd0);
      bus.ext_data = 16'h5555;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("full_hold_count", 32'(bus.in_count), 32'd4);
      end
      bus.ext_valid = 1'b0;

      // T3 drain in order; ready reopens only after the first pop edge
      for (int i = 1; i <= 4; i++) begin
         bus.ld_inr = 1'b1;
         #1;
         chk("drain_data", 32'(bus.in_data), 32'(16'h1111 * i));
         if (i == 1) chk("no_comb_ready", 32'(bus.ext_ready), 32'd0);
         tick();
         bus.ld_inr = 1'b0;
         if (i == 1) chk("ready_after_pop", 32'(bus.ext_ready), 32'd1);
      end
      chk("drain_empty", 32'(bus.in_empty), 32'd1);
      chk("drain_count", 32'(bus.in_count), 32'd0);
      chk("drain_nounder", 32'(bus.underrun), 32'd0);

      // T4 concurrent push/pop at count=2, crossing the pointer wrap
      for (int i = 0; i < 2; i++) begin
         bus.ext_valid = 1'b1;
         bus.ext_data  = 16'(16'h0A00 + i);
         tick();
      end
      chk("conc_pre_count", 32'(bus.in_count), 32'd2);
      for (int i = 0; i < 10; i++) begin
         bus.ext_valid = 1'b1;
         bus.ext_data  = 16'(16'h0A02 + i);
         bus.ld_inr    = 1'b1;
         #1;
         chk("conc_data", 32'(bus.in_data), 32'(16'h0A00 + i));
         tick();
         chk("conc_count", 32'(bus.in_count), 32'd2);
      end
      bus.ext_valid = 1'b0;
      for (int i = 0; i < 2; i++) begin
         bus.ld_inr = 1'b1;
         #1;
         chk("conc_tail", 32'(bus.in_data), 32'(16'h0A0A + i));
         tick();
      end
      bus.ld_inr = 1'b0;
      chk("conc_empty", 32'(bus.in_empty), 32'd1);

      // T5 underrun
      bus.ld_inr = 1'b1;
      #1;
      chk("under_data", 32'(bus.in_data), 32'h0);
      tick();
      chk("under_flag", 32'(bus.underrun), 32'd1);
      chk("under_count", 32'(bus.in_count), 32'd0);
      bus.ext_valid = 1'b1;
      bus.ext_data  = 16'hBEEF;
      tick();
      bus.ext_valid = 1'b0;
      bus.ld_inr    = 1'b0;
      #1;
      chk("under_push_count", 32'(bus.in_count), 32'd1);
      chk("under_push_data", 32'(bus.in_data), 32'hBEEF);
      bus.ld_inr = 1'b1;
      tick();
      bus.ld_inr  = 1'b0;
      bus.clr_err = 1'b1;
      tick();
      chk("clr_err", 32'(bus.underrun), 32'd0);
      bus.ld_inr = 1'b1;
      tick();
      chk("set_beats_clr", 32'(bus.underrun), 32'd1);
      bus.ld_inr  = 1'b0;
      bus.clr_err = 1'b0;

      // T6 reset with push and pop pending and 3 words buffered
      for (int i = 1; i <= 3; i++) begin
         bus.ext_valid = 1'b1;
         bus.ext_data  = 16'(16'h0300 + i);
         tick();
      end
      chk("mid_pre_count", 32'(bus.in_count), 32'd3);
      rst           = 1'b1;
      bus.ext_data  = 16'h9999;
      bus.ld_inr    = 1'b1;
      tick();
      rst           = 1'b0;
      bus.ext_valid = 1'b0;
      bus.ld_inr    = 1'b0;
      #1;
      chk("mid_rst_count", 32'(bus.in_count), 32'd0);
      chk("mid_rst_empty", 32'(bus.in_empty), 32'd1);
      chk("mid_rst_under", 32'(bus.underrun), 32'd0);
      bus.ext_valid = 1'b1;
      bus.ext_data  = 16'h7777;
      tick();
      bus.ext_valid = 1'b0;
      #1;
      chk("post_rst_head", 32'(bus.in_data), 32'h7777);
      chk("post_rst_count", 32'(bus.in_count), 32'd1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
